mem_stage_ctrl: RTL and testbench

- MEM-stage control block sitting on the output side of the EX/MEM pipeline latch.
- Consumes the latched dREN/dWEN/datomic/address/store data and drives the data-cache request interface, holding the request until dhit.
- Produces the stall that clears the pipeline latch enables, captures load data for MEM/WB, and owns the LL/SC link register, including snoop invalidation.

---
 rtl/mem_stage_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage control. Issues the data-cache request held in the
//               EX/MEM latch, stalls the pipe until dhit, captures load data,
//               and owns the LL/SC link register with snoop invalidation.
//               Optional counters enabled by defining MEM_STAGE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int WORD_W   = 32,
    parameter int LINK_LSB = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              exm_dREN,
    input  logic              exm_dWEN,
    input  logic              exm_datomic,
    input  logic [WORD_W-1:0] exm_addr,
    input  logic [WORD_W-1:0] exm_store,
    input  logic              exm_halt,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              inv_valid,
    input  logic [WORD_W-1:0] inv_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] load_data,
    output logic              load_valid,
    output logic              halt
`ifdef MEM_STAGE_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_stall_cycles
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [WORD_W-1:0] WORD_ONE = {{(WORD_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic              r_ren;
    logic              r_wen;
    logic              r_atomic;
    logic              r_sc_ok;
    logic              r_halted;
    logic [WORD_W-1:0] r_load_data;
    logic              r_link_valid;
    logic [WORD_W-1:0] r_link_addr;

    logic w_mem_op;
    logic w_op_go;
    logic w_is_sc;
    logic w_inv_link;
    logic w_inv_req;
    logic w_sc_match;
    logic w_ll_done;
    logic w_sc_done;

    assign w_mem_op = exm_dREN | exm_dWEN;
    assign w_op_go  = w_mem_op & ~r_halted;
    assign w_is_sc  = exm_dWEN & exm_datomic;

    // Link compares ignore the byte-within-word bits.
    assign w_inv_link = inv_valid & r_link_valid &
                        ((inv_addr >> LINK_LSB) == (r_link_addr >> LINK_LSB));
    assign w_inv_req  = inv_valid &
                        ((inv_addr >> LINK_LSB) == (exm_addr >> LINK_LSB));
    assign w_sc_match = r_link_valid & ~w_inv_link &
                        ((exm_addr >> LINK_LSB) == (r_link_addr >> LINK_LSB));

    assign w_ll_done = (r_state == ST_ACCESS) & dhit & r_ren & r_atomic;
    assign w_sc_done = (r_state == ST_DONE) & r_wen & r_atomic;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_ren       <= 1'b0;
            r_wen       <= 1'b0;
            r_atomic    <= 1'b0;
            r_sc_ok     <= 1'b0;
            r_halted    <= 1'b0;
            r_load_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_op_go) begin
                        r_ren    <= exm_dREN;
                        r_wen    <= exm_dWEN;
                        r_atomic <= exm_datomic;
                        // A failing SC never touches the cache.
                        if (w_is_sc && !w_sc_match) begin
                            r_sc_ok     <= 1'b0;
                            r_load_data <= '0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_sc_ok <= w_is_sc;
                            r_state <= ST_ACCESS;
                        end
                    end else if (exm_halt && !w_mem_op) begin
                        r_halted <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (dhit) begin
                        if (r_sc_ok) begin
                            r_load_data <= WORD_ONE;
                        end else if (r_ren) begin
                            r_load_data <= dmemload;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (exm_halt) begin
                        r_halted <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // An invalidate hitting the word being linked wins over the LL.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (w_ll_done) begin
            r_link_valid <= ~w_inv_req;
            r_link_addr  <= exm_addr;
        end else if (w_inv_link || w_sc_done) begin
            r_link_valid <= 1'b0;
        end
    end

    always_comb begin
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        dmemaddr   = '0;
        dmemstore  = '0;
        mem_stall  = 1'b0;
        load_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mem_stall = w_op_go;
            end
            ST_ACCESS: begin
                dmemREN   = r_ren;
                dmemWEN   = r_wen;
                dmemaddr  = exm_addr;
                dmemstore = r_wen ? (r_sc_ok ? WORD_ONE : exm_store) : '0;
                mem_stall = 1'b1;
            end
            ST_DONE: begin
                load_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_data = r_load_data;
    assign halt      = r_halted;

`ifdef MEM_STAGE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_loads        <= '0;
            stat_stores       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (r_state == ST_DONE && r_ren) begin
                stat_loads <= stat_loads + 32'd1;
            end
            if (r_state == ST_DONE && r_wen && (!r_atomic || r_sc_ok)) begin
                stat_stores <= stat_stores + 32'd1;
            end
            if (mem_stall) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Scoreboard bench for mem_stage_ctrl with a cache responder
//               and a transaction-level LL/SC reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int K_NOP = 0, K_LD = 1, K_ST = 2, K_LL = 3, K_SC = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        exm_dREN, exm_dWEN, exm_datomic, exm_halt;
    logic [31:0] exm_addr, exm_store;
    logic        dhit;
    logic [31:0] dmemload;
    logic        inv_valid;
    logic [31:0] inv_addr;
    logic        dmemREN, dmemWEN, mem_stall, load_valid, halt;
    logic [31:0] dmemaddr, dmemstore, load_data;
`ifdef MEM_STAGE_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_stall_cycles;
`endif

    always #5 CLK = ~CLK;

    mem_stage_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .exm_dREN(exm_dREN), .exm_dWEN(exm_dWEN), .exm_datomic(exm_datomic),
        .exm_addr(exm_addr), .exm_store(exm_store), .exm_halt(exm_halt),
        .dhit(dhit), .dmemload(dmemload),
        .inv_valid(inv_valid), .inv_addr(inv_addr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall),
        .load_data(load_data), .load_valid(load_valid), .halt(halt)
`ifdef MEM_STAGE_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores),
        .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    typedef struct { bit wen; logic [31:0] addr; logic [31:0] data; } req_t;
    typedef struct { bit chk; logic [31:0] val; } res_t;

    req_t req_q[$];
    res_t res_q[$];

    int tests = 0;
    int failed = 0;

    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] cache_mem [logic [31:0]];
    bit          m_link_v;
    logic [31:0] m_link_a;

    int cur_d = 0;
    bit inv_at_dhit = 0;
    bit inv_dhit_active = 0;
    int cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        failed++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    task automatic push_req(input bit wen, input logic [31:0] a, input logic [31:0] d);
        req_t e;
        e.wen = wen; e.addr = a; e.data = d;
        req_q.push_back(e);
    endtask

    task automatic push_res(input bit c, input logic [31:0] v);
        res_t e;
        e.chk = c; e.val = v;
        res_q.push_back(e);
    endtask

    // Cache responder: answers each request after cur_d extra cycles.
    initial begin
        req_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (!nRST) begin
                dhit = 0;
                cnt  = 0;
            end else if (dhit) begin
                dhit     = 0;
                cnt      = 0;
                dmemload = $urandom;
                if (inv_dhit_active) begin
                    inv_valid       = 0;
                    inv_dhit_active = 0;
                end
            end else if (dmemREN || dmemWEN) begin
                if (cnt >= cur_d) begin
                    dhit     = 1;
                    dmemload = cache_mem.exists(dmemaddr) ? cache_mem[dmemaddr] : dflt(dmemaddr);
                    if (req_q.size() == 0) begin
                        fail_now("unexpected_cache_request");
                    end else begin
                        e = req_q.pop_front();
                        chk("req_wen", dmemWEN, e.wen);
                        chk("req_ren", dmemREN, !e.wen);
                        chk("req_addr", dmemaddr, e.addr);
                        if (e.wen) chk("req_data", dmemstore, e.data);
                    end
                    if (dmemWEN) cache_mem[dmemaddr] = dmemstore;
                    if (inv_at_dhit) begin
                        inv_valid       = 1;
                        inv_addr        = dmemaddr | 32'h2;
                        inv_dhit_active = 1;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Result monitor: every load_valid pulse consumes one expected result.
    initial begin
        res_t r;
        forever begin
            @(negedge CLK);
            if (nRST === 1'b1 && load_valid === 1'b1) begin
                if (res_q.size() == 0) begin
                    fail_now("unexpected_load_valid");
                end else begin
                    r = res_q.pop_front();
                    if (r.chk) chk("load_data", load_data, r.val);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the op has left the stage.
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input int d, input bit inv_first, input bit inv_dhit);
        bit access;
        bit ok;
        int stall, reqc, n;
        access = (kind != K_NOP);
        ok = 1;
        case (kind)
            K_LD, K_LL: begin
                push_req(0, addr, 32'h0);
                push_res(1, ref_read(addr));
                if (kind == K_LL) begin
                    m_link_v = !inv_dhit;
                    m_link_a = addr;
                end
            end
            K_ST: begin
                push_req(1, addr, data);
                ref_mem[addr] = data;
                push_res(0, 32'h0);
            end
            K_SC: begin
                if (inv_first && m_link_v && same_word(addr, m_link_a)) m_link_v = 0;
                ok = m_link_v && same_word(addr, m_link_a);
                m_link_v = 0;
                access = ok;
                if (ok) begin
                    push_req(1, addr, 32'h1);
                    ref_mem[addr] = 32'h1;
                end
                push_res(1, ok ? 32'h1 : 32'h0);
            end
            default: ;
        endcase
        cur_d       = d;
        inv_at_dhit = inv_dhit;
        exm_dREN    = (kind == K_LD || kind == K_LL);
        exm_dWEN    = (kind == K_ST || kind == K_SC);
        exm_datomic = (kind == K_LL || kind == K_SC);
        exm_addr    = addr;
        exm_store   = data;
        if (inv_first) begin
            inv_valid = 1;
            inv_addr  = addr;
        end
        stall = 0; reqc = 0; n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (mem_stall) stall++;
            if (dmemREN || dmemWEN) reqc++;
            if (!mem_stall || n > 60) break;
            @(posedge CLK);
            #1;
            if (inv_first) inv_valid = 0;
        end
        chk("op_within_budget", (n <= 60), 1);
        chk("stall_cycles", stall, access ? d + 2 : (kind == K_NOP ? 0 : 1));
        chk("request_cycles", reqc, access ? d + 1 : 0);
        @(posedge CLK);
        #1;
        if (inv_first) inv_valid = 0;
        exm_dREN = 0; exm_dWEN = 0; exm_datomic = 0; exm_addr = 0; exm_store = 0;
        inv_at_dhit = 0;
    endtask

    task automatic gap_inv(input logic [31:0] a);
        inv_valid = 1;
        inv_addr  = a;
        if (m_link_v && same_word(a, m_link_a)) m_link_v = 0;
        @(negedge CLK);
        chk("gap_stall", mem_stall, 0);
        @(posedge CLK);
        #1;
        inv_valid = 0;
    endtask

    task automatic do_reset();
        nRST = 0;
        exm_dREN = 0; exm_dWEN = 0; exm_datomic = 0; exm_halt = 0;
        m_link_v = 0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d;
        logic [31:0] a;
        nRST = 0;
        exm_dREN = 0; exm_dWEN = 0; exm_datomic = 0; exm_halt = 0;
        exm_addr = 0; exm_store = 0;
        dhit = 0; dmemload = 0; inv_valid = 0; inv_addr = 0;
        m_link_v = 0; m_link_a = 0;
        ref_mem[32'h40]   = 32'hDEAD_BEEF;
        cache_mem[32'h40] = 32'hDEAD_BEEF;

        repeat (2) @(negedge CLK);
        chk("rst_dmemREN", dmemREN, 0);
        chk("rst_dmemWEN", dmemWEN, 0);
        chk("rst_dmemaddr", dmemaddr, 0);
        chk("rst_dmemstore", dmemstore, 0);
        chk("rst_mem_stall", mem_stall, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_load_valid", load_valid, 0);
        chk("rst_halt", halt, 0);
        @(posedge CLK);
        #1;
        nRST = 1;

        do_op(K_LD, 32'h40, 32'h0, 1, 0, 0);
        do_op(K_NOP, 32'h0, 32'h0, 0, 0, 0);
        do_op(K_ST, 32'h80, 32'h1234, 2, 0, 0);
        do_op(K_LL, 32'h100, 32'h0, 0, 0, 0);
        do_op(K_SC, 32'h100, 32'h0, 1, 0, 0);
        do_op(K_SC, 32'h100, 32'h0, 1, 0, 0);
        do_op(K_LL, 32'h100, 32'h0, 1, 0, 0);
        gap_inv(32'h102);
        do_op(K_SC, 32'h100, 32'h0, 0, 0, 0);
        do_op(K_LL, 32'h200, 32'h0, 0, 0, 1);
        do_op(K_SC, 32'h200, 32'h0, 0, 0, 0);
        do_op(K_LL, 32'h300, 32'h0, 0, 0, 0);
        do_op(K_SC, 32'h300, 32'h0, 0, 1, 0);

        // Asynchronous reset while a load waits in ACCESS
        do_op(K_LL, 32'h400, 32'h0, 0, 0, 0);
        exm_dREN = 1;
        exm_addr = 32'h500;
        cur_d    = 40;
        repeat (3) @(negedge CLK);
        chk("pre_reset_request", dmemREN, 1);
        #2;
        nRST = 0;
        #1;
        chk("async_rst_dmemREN", dmemREN, 0);
        chk("async_rst_dmemWEN", dmemWEN, 0);
        chk("async_rst_load_valid", load_valid, 0);
        exm_dREN = 0;
        exm_addr = 0;
        m_link_v = 0;
        #1;
        chk("async_rst_mem_stall", mem_stall, 0);
        @(posedge CLK);
        #1;
        nRST = 1;
        do_op(K_SC, 32'h400, 32'h0, 0, 0, 0);

        // Halt without a memory op, then a load must be ignored
        exm_halt = 1;
        @(negedge CLK);
        chk("halt_cycle_stall", mem_stall, 0);
        @(posedge CLK);
        #1;
        exm_halt = 0;
        chk("halt_set", halt, 1);
        exm_dREN = 1;
        exm_addr = 32'h700;
        repeat (4) begin
            @(negedge CLK);
            chk("halted_no_request", dmemREN, 0);
            chk("halted_no_stall", mem_stall, 0);
            chk("halt_sticky", halt, 1);
        end
        @(posedge CLK);
        #1;
        exm_dREN = 0;
        do_reset();
        chk("halt_cleared_by_reset", halt, 0);

`ifdef MEM_STAGE_STATS_EN
        do_reset();
        do_op(K_LD, 32'h40, 32'h0, 0, 0, 0);
        do_op(K_LD, 32'h44, 32'h0, 0, 0, 0);
        do_op(K_SC, 32'h600, 32'h0, 0, 0, 0);
        chk("stat_loads", stat_loads, 2);
        chk("stat_stores", stat_stores, 0);
        chk("stat_stall_cycles", stat_stall_cycles, 5);
`endif

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 5);
            a = 32'h100 + 4 * $urandom_range(0, 3);
            d = $urandom_range(0, 3);
            if (k == 5) begin
                gap_inv(a | $urandom_range(0, 3));
            end else begin
                do_op(k, a, $urandom, d,
                      (k == K_SC) && ($urandom_range(0, 3) == 0),
                      (k == K_LL) && ($urandom_range(0, 3) == 0));
            end
        end

        repeat (3) @(negedge CLK);
        chk("results_drained", res_q.size(), 0);
        chk("requests_drained", req_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
